// File: rtl/alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_stage
// Brief    : ID->EX ALU control register with MIPS decode, stall/flush and a
//            one-shot overflow trap. ALU_CTRL_ILLEGAL_TRAP_EN adds illegal_trap.
// Revision : 1.0  initial release
// ============================================================================
module alu_ctrl_stage #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_id,
  input  logic [5:0]      opcode_id,
  input  logic [5:0]      funct_id,
  input  logic [4:0]      shamt_id,
  input  logic [PC_W-1:0] pc_id,
  input  logic            stall,
  input  logic            flush,
  input  logic            alu_overflow,
  output logic            valid_ex,
  output logic [2:0]      alu_op_ex,
  output logic [4:0]      shamt_ex,
  output logic            alu_src_imm_ex,
  output logic            imm_zext_ex,
  output logic            ovf_chk_ex,
  output logic            reg_write_ex,
  output logic            illegal_ex,
  output logic            ovf_trap,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  output logic            illegal_trap,
`endif
  output logic [PC_W-1:0] trap_pc
);

  typedef struct packed {
    logic       valid;
    logic [2:0] alu_op;
    logic [4:0] shamt;
    logic       src_imm;
    logic       zext;
    logic       chk;
    logic       wr;
    logic       ill;
  } ctl_t;

  localparam ctl_t c_bubble = '{1'b0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  ctl_t            ctl_q, ctl_d, w_dec;
  logic [PC_W-1:0] pc_ex_q, pc_ex_d;
  logic [PC_W-1:0] trap_pc_q, trap_pc_d;
  logic            trapped_ex_q, trapped_ex_d;
  logic            ovf_trap_q, ovf_trap_d;
  logic            ill_trap_q, ill_trap_d;
  logic            w_ovf_hit, w_ill_hit, w_any_hit;

  // Anything not matched below stays illegal: pass op, no writeback.
  always_comb begin
    w_dec        = c_bubble;
    w_dec.valid  = 1'b1;
    w_dec.ill    = 1'b1;
    case (opcode_id)
      6'h00: begin
        case (funct_id)
          6'h20: begin w_dec.alu_op = 3'b010; w_dec.chk = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h21: begin w_dec.alu_op = 3'b010; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h22: begin w_dec.alu_op = 3'b110; w_dec.chk = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h23: begin w_dec.alu_op = 3'b110; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h24: begin w_dec.alu_op = 3'b000; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h25: begin w_dec.alu_op = 3'b001; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h2A: begin w_dec.alu_op = 3'b111; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
          6'h00: begin
            w_dec.alu_op = 3'b011;
            w_dec.shamt  = shamt_id;
            w_dec.wr     = 1'b1;
            w_dec.ill    = 1'b0;
          end
          default: ;
        endcase
      end
      6'h08: begin w_dec.alu_op = 3'b010; w_dec.src_imm = 1'b1; w_dec.chk = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
      6'h09: begin w_dec.alu_op = 3'b010; w_dec.src_imm = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
      6'h0C: begin w_dec.alu_op = 3'b000; w_dec.src_imm = 1'b1; w_dec.zext = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
      6'h0D: begin w_dec.alu_op = 3'b001; w_dec.src_imm = 1'b1; w_dec.zext = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
      6'h0A: begin w_dec.alu_op = 3'b111; w_dec.src_imm = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
      6'h23: begin w_dec.alu_op = 3'b010; w_dec.src_imm = 1'b1; w_dec.wr = 1'b1; w_dec.ill = 1'b0; end
      6'h2B: begin w_dec.alu_op = 3'b010; w_dec.src_imm = 1'b1; w_dec.ill = 1'b0; end
      6'h04, 6'h05: begin w_dec.alu_op = 3'b110; w_dec.ill = 1'b0; end
      6'h02: begin w_dec.alu_op = 3'b100; w_dec.ill = 1'b0; end
      default: ;
    endcase
    if (!valid_id) begin
      w_dec = c_bubble;
    end
  end

  // trapped_ex_q keeps a stalled instruction from trapping more than once.
  assign w_ovf_hit = ctl_q.valid & ctl_q.chk & alu_overflow & ~trapped_ex_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign w_ill_hit = ctl_q.valid & ctl_q.ill & ~trapped_ex_q;
`else
  assign w_ill_hit = 1'b0;
`endif
  assign w_any_hit = w_ovf_hit | w_ill_hit;

  always_comb begin
    ctl_d        = ctl_q;
    pc_ex_d      = pc_ex_q;
    trapped_ex_d = trapped_ex_q;
    ovf_trap_d   = w_ovf_hit;
    ill_trap_d   = w_ill_hit;
    trap_pc_d    = w_any_hit ? pc_ex_q : trap_pc_q;
    if (flush) begin
      ctl_d        = c_bubble;
      pc_ex_d      = '0;
      trapped_ex_d = 1'b0;
    end else if (stall) begin
      trapped_ex_d = trapped_ex_q | w_any_hit;
    end else begin
      ctl_d        = w_dec;
      pc_ex_d      = pc_id;
      trapped_ex_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_q        <= c_bubble;
      pc_ex_q      <= '0;
      trap_pc_q    <= '0;
      trapped_ex_q <= 1'b0;
      ovf_trap_q   <= 1'b0;
      ill_trap_q   <= 1'b0;
    end else begin
      ctl_q        <= ctl_d;
      pc_ex_q      <= pc_ex_d;
      trap_pc_q    <= trap_pc_d;
      trapped_ex_q <= trapped_ex_d;
      ovf_trap_q   <= ovf_trap_d;
      ill_trap_q   <= ill_trap_d;
    end
  end

  assign valid_ex       = ctl_q.valid;
  assign alu_op_ex      = ctl_q.alu_op;
  assign shamt_ex       = ctl_q.shamt;
  assign alu_src_imm_ex = ctl_q.src_imm;
  assign imm_zext_ex    = ctl_q.zext;
  assign ovf_chk_ex     = ctl_q.chk;
  assign reg_write_ex   = ctl_q.wr;
  assign illegal_ex     = ctl_q.ill;
  assign ovf_trap       = ovf_trap_q;
  assign trap_pc        = trap_pc_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  assign illegal_trap   = ill_trap_q;
`else
  logic w_unused_ill_trap;
  assign w_unused_ill_trap = ill_trap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ctrl_stage
// Brief    : Directed + random bench for alu_ctrl_stage against a table-driven
//            reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_id = 1'b0;
  logic [5:0]  opcode_id = '0;
  logic [5:0]  funct_id = '0;
  logic [4:0]  shamt_id = '0;
  logic [31:0] pc_id = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        valid_ex, ovf_trap, alu_src_imm_ex, imm_zext_ex, ovf_chk_ex, reg_write_ex, illegal_ex;
  logic [2:0]  alu_op_ex;
  logic [4:0]  shamt_ex;
  logic [31:0] trap_pc;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
  logic        illegal_trap;
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  alu_ctrl_stage #(.PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .opcode_id(opcode_id),
    .funct_id(funct_id), .shamt_id(shamt_id), .pc_id(pc_id), .stall(stall),
    .flush(flush), .alu_overflow(alu_overflow), .valid_ex(valid_ex),
    .alu_op_ex(alu_op_ex), .shamt_ex(shamt_ex), .alu_src_imm_ex(alu_src_imm_ex),
    .imm_zext_ex(imm_zext_ex), .ovf_chk_ex(ovf_chk_ex), .reg_write_ex(reg_write_ex),
    .illegal_ex(illegal_ex), .ovf_trap(ovf_trap),
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    .illegal_trap(illegal_trap),
`endif
    .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  // Reference: instruction table straight from the decode rules.
  typedef struct packed {
    logic [5:0] opc; logic [5:0] fn; logic rtype; logic [2:0] op;
    logic imm; logic zx; logic chk; logic wr;
  } ent_t;

  ent_t tbl [0:17] = '{
    '{6'h00, 6'h20, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b1},
    '{6'h00, 6'h21, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'h00, 6'h22, 1'b1, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
    '{6'h00, 6'h23, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'h00, 6'h24, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'h00, 6'h25, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'h00, 6'h2A, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'h00, 6'h00, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1},
    '{6'h08, 6'h00, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1},
    '{6'h09, 6'h00, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1},
    '{6'h0C, 6'h00, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1},
    '{6'h0D, 6'h00, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b1},
    '{6'h0A, 6'h00, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b1},
    '{6'h23, 6'h00, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1},
    '{6'h2B, 6'h00, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0},
    '{6'h04, 6'h00, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0},
    '{6'h05, 6'h00, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0},
    '{6'h02, 6'h00, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0}
  };

  typedef struct packed {
    logic v; logic [2:0] op; logic [4:0] sh; logic imm; logic zx; logic chk; logic wr; logic ill;
  } exp_t;

  exp_t        m_ex;
  logic [31:0] m_pc_ex, m_tpc;
  logic        m_trapped, m_trap, m_itrap;
  int          checks = 0;
  int          errors = 0;

  function automatic exp_t ref_decode(input logic v, input logic [5:0] opc,
                                      input logic [5:0] fn, input logic [4:0] sh);
    exp_t r;
    r = '{1'b0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if (!v) return r;
    r.v = 1'b1; r.ill = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (tbl[i].rtype ? (opc == 6'h00 && fn == tbl[i].fn) : (opc == tbl[i].opc)) begin
        r.op = tbl[i].op; r.imm = tbl[i].imm; r.zx = tbl[i].zx;
        r.chk = tbl[i].chk; r.wr = tbl[i].wr; r.ill = 1'b0;
        r.sh = (tbl[i].rtype && fn == 6'h00) ? sh : 5'd0;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_edge();
    logic hit_o, hit_i;
    if (!rst_n) begin
      m_ex = '{1'b0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      m_pc_ex = '0; m_tpc = '0; m_trapped = 1'b0; m_trap = 1'b0; m_itrap = 1'b0;
    end else begin
      hit_o = m_ex.v && m_ex.chk && alu_overflow && !m_trapped;
      hit_i = ILL_EN && m_ex.v && m_ex.ill && !m_trapped;
      m_trap = hit_o; m_itrap = hit_i;
      if (hit_o || hit_i) m_tpc = m_pc_ex;
      if (flush) begin
        m_ex = '{1'b0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        m_trapped = 1'b0;
      end else if (stall) begin
        m_trapped = m_trapped || hit_o || hit_i;
      end else begin
        m_ex = ref_decode(valid_id, opcode_id, funct_id, shamt_id);
        m_pc_ex = pc_id; m_trapped = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("valid_ex", {31'd0, valid_ex}, {31'd0, m_ex.v});
    check("alu_op_ex", {29'd0, alu_op_ex}, {29'd0, m_ex.op});
    check("shamt_ex", {27'd0, shamt_ex}, {27'd0, m_ex.sh});
    check("alu_src_imm_ex", {31'd0, alu_src_imm_ex}, {31'd0, m_ex.imm});
    check("imm_zext_ex", {31'd0, imm_zext_ex}, {31'd0, m_ex.zx});
    check("ovf_chk_ex", {31'd0, ovf_chk_ex}, {31'd0, m_ex.chk});
    check("reg_write_ex", {31'd0, reg_write_ex}, {31'd0, m_ex.wr});
    check("illegal_ex", {31'd0, illegal_ex}, {31'd0, m_ex.ill});
    check("ovf_trap", {31'd0, ovf_trap}, {31'd0, m_trap});
    check("trap_pc", trap_pc, m_tpc);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    check("illegal_trap", {31'd0, illegal_trap}, {31'd0, m_itrap});
`endif
  endtask

  task automatic set_id(input logic v, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [4:0] sh, input logic [31:0] pc);
    valid_id = v; opcode_id = opc; funct_id = fn; shamt_id = sh; pc_id = pc;
  endtask

  int pulses;

  initial begin
    // Reset held two cycles with a live add in ID
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 32'h10);
    rst_n = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, valid_ex}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op_ex}, 32'd4);
    check("rst_trap_pc", trap_pc, 32'd0);
    rst_n = 1'b1;

    // Decode sweep
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 32'h100); step();
    set_id(1'b1, 6'h00, 6'h23, 5'd0, 32'h104); step();
    set_id(1'b1, 6'h0C, 6'h00, 5'd0, 32'h108); step();
    set_id(1'b1, 6'h0D, 6'h00, 5'd0, 32'h10C); step();
    set_id(1'b1, 6'h0A, 6'h00, 5'd0, 32'h110); step();
    set_id(1'b1, 6'h00, 6'h00, 5'd7, 32'h114); step();
    check("sll_shamt", {27'd0, shamt_ex}, 32'd7);
    check("sll_op", {29'd0, alu_op_ex}, 32'd3);
    set_id(1'b1, 6'h23, 6'h00, 5'd0, 32'h118); step();
    set_id(1'b1, 6'h2B, 6'h00, 5'd0, 32'h11C); step();
    check("sw_wr", {31'd0, reg_write_ex}, 32'd0);
    set_id(1'b1, 6'h04, 6'h00, 5'd0, 32'h120); step();
    set_id(1'b1, 6'h02, 6'h00, 5'd0, 32'h124); step();
    check("j_op", {29'd0, alu_op_ex}, 32'd4);

    // Stall holds, flush beats stall
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 32'h200); step();
    stall = 1'b1;
    set_id(1'b1, 6'h0D, 6'h00, 5'd0, 32'h204); step(); step(); step();
    check("stall_hold_op", {29'd0, alu_op_ex}, 32'd2);
    flush = 1'b1; step();
    check("flush_bubble", {31'd0, valid_ex}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Overflow trap on addi, none on addiu
    set_id(1'b1, 6'h08, 6'h00, 5'd0, 32'h40); step();
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 32'h44); alu_overflow = 1'b1; step();
    check("addi_trap", {31'd0, ovf_trap}, 32'd1);
    check("addi_trap_pc", trap_pc, 32'h40);
    alu_overflow = 1'b0;
    set_id(1'b1, 6'h09, 6'h00, 5'd0, 32'h80); step();
    check("trap_one_cycle", {31'd0, ovf_trap}, 32'd0);
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 32'h84); alu_overflow = 1'b1; step();
    check("addiu_no_trap", {31'd0, ovf_trap}, 32'd0);
    check("trap_pc_hold", trap_pc, 32'h40);
    alu_overflow = 1'b0;

    // Stalled overflow traps once
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 32'h300); step();
    stall = 1'b1; alu_overflow = 1'b1; pulses = 0;
    set_id(1'b1, 6'h00, 6'h22, 5'd0, 32'h304);
    for (int i = 0; i < 4; i++) begin step(); pulses += int'(ovf_trap); end
    stall = 1'b0; alu_overflow = 1'b0; step(); pulses += int'(ovf_trap);
    check("stall_one_pulse", pulses, 32'd1);
    check("stall_trap_pc", trap_pc, 32'h300);

    // Flush coinciding with a trap
    set_id(1'b1, 6'h00, 6'h22, 5'd0, 32'h400); step();
    flush = 1'b1; alu_overflow = 1'b1; step();
    check("flush_trap", {31'd0, ovf_trap}, 32'd1);
    flush = 1'b0; alu_overflow = 1'b0;

    // Illegal instruction
    set_id(1'b1, 6'h3F, 6'h00, 5'd0, 32'h500); step();
    check("illegal_flag", {31'd0, illegal_ex}, 32'd1);
    check("illegal_wr", {31'd0, reg_write_ex}, 32'd0);
    set_id(1'b0, 6'h00, 6'h00, 5'd0, 32'h504); step(); step();

    // Reset mid-operation discards EX and the pending trap
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 32'h600); step();
    alu_overflow = 1'b1; rst_n = 1'b0; step();
    check("rst_mid_trap", {31'd0, ovf_trap}, 32'd0);
    rst_n = 1'b1; alu_overflow = 1'b0;

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      int k;
      rst_n        = ($urandom % 64) != 0;
      stall        = ($urandom % 4) == 0;
      flush        = ($urandom % 10) == 0;
      alu_overflow = $urandom % 2;
      k = $urandom % 20;
      if (k < 18) set_id(($urandom % 8) != 0, tbl[k].opc, tbl[k].fn, 5'($urandom), $urandom);
      else if (k == 18) set_id(1'b1, 6'h3F, 6'($urandom), 5'($urandom), $urandom);
      else set_id(1'b1, 6'h00, 6'h3F, 5'($urandom), $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
- Registered ID→EX control stage that drives the EX-stage ALU (alu_op, shamt, operand-select).
- Decodes MIPS opcode/funct into the 3-bit ALU operation code, then holds it in the ID/EX control register.
- The register supports stall (hold) and flush (bubble).
- Also consumes the ALU's Overflow output for the instruction in EX and raises a one-cycle overflow trap, capturing its PC.

Parameters:
- PC_W, 32, width of pc_id / trap_pc.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- valid_id  in  1  ID stage holds a real instruction
- opcode_id  in  6  instr[31:26]
- funct_id  in  6  instr[5:0]
- shamt_id  in  5  instr[10:6]
- pc_id  in  PC_W  PC of ID instruction
- stall  in  1  hold EX register contents
- flush  in  1  load bubble into EX register
- alu_overflow  in  1  ALU Overflow for instruction currently in EX
- valid_ex  out  1  EX register holds a real instruction
- alu_op_ex  out  3  ALU operation code
- shamt_ex  out  5  shift amount to ALU
- alu_src_imm_ex  out  1  Input2 = immediate
- imm_zext_ex  out  1  immediate zero-extended (else sign-extended)
- ovf_chk_ex  out  1  overflow is architecturally checked
- reg_write_ex  out  1  result is written back
- illegal_ex  out  1  undecodable instruction
- ovf_trap  out  1  one-cycle overflow trap pulse
- trap_pc  out  PC_W  PC of the trapping instruction

Behaviour:
- ALU codes: 010 add, 110 sub, 000 and, 001 or, 011 sll, 111 slt, 100 pass (Input1).
- Decode table, R-type (opcode 0x00), by funct:
  - 0x20 add: 010, chk=1
  - 0x21 addu: 010, chk=0
  - 0x22 sub: 110, chk=1
  - 0x23 subu: 110, chk=0
  - 0x24 and: 000
  - 0x25 or: 001
  - 0x2A slt: 111
  - 0x00 sll: 011, shamt=shamt_id
  - All R-type: src_imm=0, reg_write=1.
- Decode table, other opcodes:
  - 0x08 addi: 010, imm, sext, chk=1, wr=1
  - 0x09 addiu: 010, imm, sext, chk=0, wr=1
  - 0x0C andi: 000, imm, zext, wr=1
  - 0x0D ori: 001, imm, zext, wr=1
  - 0x0A slti: 111, imm, sext, wr=1
  - 0x23 lw: 010, imm, sext, wr=1
  - 0x2B sw: 010, imm, sext, wr=0
  - 0x04 beq / 0x05 bne: 110, src_imm=0, wr=0
  - 0x02 j: 100, wr=0
- Defaults: shamt_ex=0 except sll; chk=0 unless listed.
- Any other opcode/funct decodes as illegal: 100, wr=0, chk=0, illegal=1.
- Register update, priority order at each rising edge:
  1. !rst_n: load bubble and clear trap state.
  2. flush: load bubble.
  3. stall: hold all EX outputs.
  4. Otherwise: load decode of ID; valid_ex=valid_id.
- Bubble: valid=0, alu_op=100, shamt=0, all flags 0.
- valid_id=0 loads a bubble-equivalent (all control zero).
- Latency: exactly 1 cycle from ID inputs to EX outputs.
- Trap detection: each cycle, the registered trap pulse is set when valid_ex & ovf_chk_ex & alu_overflow.
  - ovf_trap is asserted the following cycle, for exactly 1 cycle.
  - trap_pc latches the PC held in the EX register (internal pc_ex) at the same edge.
  - trap_pc holds until the next trap or reset.
- Stall with overflow: alu_overflow is sampled while stall=1, but a held instruction traps only once.
  - An internal trapped_ex flag is set on the trap and cleared on any EX reload.
- Flush and trap on the same edge: the trap is still raised; the EX register becomes a bubble.
- Reset values: every output 0 except alu_op_ex=100; trap_pc=0.
- Reset mid-operation: one rst_n=0 cycle discards the EX instruction and any pending trap.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined: a valid illegal instruction reaching EX raises ovf_trap-style pulse on illegal_trap (extra 1-bit output port) the next cycle and latches trap_pc, with the same one-shot-under-stall rule.
- Undefined: the illegal_trap port is absent; illegal instructions flow as NOPs (wr=0) with illegal_ex=1 only.

Test Plan:
- Reset: hold rst_n=0 two cycles with valid_id=1 add → valid_ex=0, alu_op_ex=100, ovf_trap=0, trap_pc=0.
- Decode sweep: one instruction per cycle (add, subu, andi, ori, slti, sll shamt=7, lw, sw, beq, j) → next-cycle alu_op_ex 010,110,000,001,111,011(shamt_ex=7),010,010,110,100 with listed flags.
- Stall/flush: load add, assert stall 3 cycles with new ID input → EX unchanged; then flush=1 with stall=1 → bubble next cycle.
- Overflow: addi at pc=0x40 in EX with alu_overflow=1 → ovf_trap=1 for one cycle, trap_pc=0x40; addiu with alu_overflow=1 → no trap.
- Stalled overflow: add in EX, stall 4 cycles, alu_overflow=1 throughout → exactly one ovf_trap pulse.
- Illegal: opcode 0x3F → illegal_ex=1, reg_write_ex=0; with ALU_CTRL_ILLEGAL_TRAP_EN, illegal_trap pulses once next cycle.
